// File: rtl/lfsr_pkg.sv
// Shared types and default Galois tap masks for the LFSR pseudo-random generators.
package lfsr_pkg;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  // Maximal-length Galois masks for the common widths
  localparam logic [15:0] TAPS_16 = 16'hB400;
  localparam logic [3:0]  TAPS_4  = 4'hC;
  localparam logic [7:0]  TAPS_8  = 8'hB8;
  localparam logic [31:0] TAPS_32 = 32'h80200003;

endpackage

// File: rtl/lfsr_step.sv
// One Galois LFSR step: shift right, fold the tap mask in when the LSB falls out.
// Latency: combinational. Backpressure: none, pure function of the current state.
// Kept separate so multi-step variants can chain several instances.
module lfsr_step #(
  parameter int               WIDTH = 16,
  parameter logic [WIDTH-1:0] TAPS  = WIDTH'(16'hB400)
) (
  input  logic [WIDTH-1:0] cur,
  output logic [WIDTH-1:0] nxt
);

  assign nxt = (cur >> 1) ^ (cur[0] ? TAPS : '0);

endmodule

// File: rtl/lfsr_prng.sv
// Galois LFSR word generator with seed load, burst length and optional wrap pulse (LFSR_PERIOD_CHECK_EN).
// Latency: first word valid the cycle after load; one new word per accepted handshake.
// Backpressure: out_data is registered and holds while out_valid & !out_ready.
module lfsr_prng
  import lfsr_pkg::*;
#(
  parameter int               WIDTH        = 16,
  parameter logic [WIDTH-1:0] TAPS         = WIDTH'(TAPS_16),
  parameter logic [WIDTH-1:0] DEFAULT_SEED = WIDTH'(1),
  parameter int               LEN_W        = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] seed,
  input  logic [LEN_W-1:0] len,
  input  logic             halt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             busy,
  output logic             done,
  output logic             wrap
);

  state_t           state_q, state_n;
  logic [WIDTH-1:0] lfsr_q, lfsr_n, lfsr_nxt, seed_eff;
  logic [LEN_W-1:0] cnt_q, cnt_n;
  logic             done_q, done_n;
  logic             hs;

  lfsr_step #(.WIDTH(WIDTH), .TAPS(TAPS)) u_step (
    .cur (lfsr_q),
    .nxt (lfsr_nxt)
  );

  // A zero seed would lock the register at zero forever
  assign seed_eff = (seed == '0) ? DEFAULT_SEED : seed;
  assign hs       = (state_q == S_RUN) && out_ready;

  always_comb begin
    state_n = state_q;
    lfsr_n  = lfsr_q;
    cnt_n   = cnt_q;
    done_n  = 1'b0;
    if (load) begin
      state_n = S_RUN;
      lfsr_n  = seed_eff;
      cnt_n   = len;
    end else if (state_q == S_RUN) begin
      if (hs) begin
        lfsr_n = lfsr_nxt;
        // cnt == 0 while running means free-running: never count down
        if (cnt_q != '0) begin
          cnt_n = cnt_q - LEN_W'(1);
          if (cnt_q == LEN_W'(1)) begin
            state_n = S_IDLE;
            done_n  = 1'b1;
          end
        end
      end
      if (halt) state_n = S_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      lfsr_q  <= DEFAULT_SEED;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_n;
      lfsr_q  <= lfsr_n;
      cnt_q   <= cnt_n;
      done_q  <= done_n;
    end
  end

  assign out_valid = (state_q == S_RUN);
  assign busy      = (state_q == S_RUN);
  assign out_data  = lfsr_q;
  assign done      = done_q;

`ifdef LFSR_PERIOD_CHECK_EN
  localparam int PW = WIDTH + 1;

  logic [WIDTH-1:0] start_q;
  logic [PW-1:0]    period_q;
  logic             wrap_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      start_q  <= DEFAULT_SEED;
      period_q <= '0;
      wrap_q   <= 1'b0;
    end else begin
      wrap_q <= 1'b0;
      if (load) begin
        start_q  <= seed_eff;
        period_q <= '0;
      end else if (hs) begin
        period_q <= period_q + PW'(1);
        wrap_q   <= (lfsr_nxt == start_q);
      end
    end
  end

  assign wrap = wrap_q;
`else
  assign wrap = 1'b0;
`endif

endmodule

// File: tb/tb_lfsr_prng.sv
// Bench for lfsr_prng: directed scenarios plus a randomized run against a word-level reference model.
module tb_lfsr_prng;

  logic        clk = 1'b0;
  logic        reset, load, halt, out_ready;
  logic [15:0] seed, len, out_data;
  logic        out_valid, busy, done, wrap;

  logic        load4, out_valid4, busy4, done4, wrap4;
  logic [3:0]  seed4, out_data4;

  int pass_cnt  = 0;
  int total_cnt = 0;

`ifdef LFSR_PERIOD_CHECK_EN
  localparam bit PC_EN = 1'b1;
`else
  localparam bit PC_EN = 1'b0;
`endif

  always #5 clk = ~clk;

  lfsr_prng dut (
    .clk(clk), .reset(reset), .load(load), .seed(seed), .len(len), .halt(halt),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy), .done(done), .wrap(wrap)
  );

  lfsr_prng #(.WIDTH(4), .TAPS(4'hC), .DEFAULT_SEED(4'h1), .LEN_W(16)) u4 (
    .clk(clk), .reset(reset), .load(load4), .seed(seed4), .len(16'd0), .halt(1'b0),
    .out_valid(out_valid4), .out_ready(1'b1), .out_data(out_data4),
    .busy(busy4), .done(done4), .wrap(wrap4)
  );

  // Reference rule: shift right, xor the mask in when the dropped bit was 1
  function automatic logic [15:0] ref16(input logic [15:0] v);
    return v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
  endfunction

  function automatic logic [3:0] ref4(input logic [3:0] v);
    return v[0] ? ((v >> 1) ^ 4'hC) : (v >> 1);
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [15:0] s, input logic [15:0] l);
    load = 1'b1; seed = s; len = l;
    tick();
    load = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) tick();
    total_cnt++; if (out_valid !== 1'b0) $display("FAIL reset_valid: got %b expected 0", out_valid); else pass_cnt++;
    total_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy); else pass_cnt++;
    total_cnt++; if (done !== 1'b0) $display("FAIL reset_done: got %b expected 0", done); else pass_cnt++;
    total_cnt++; if (wrap !== 1'b0) $display("FAIL reset_wrap: got %b expected 0", wrap); else pass_cnt++;
    total_cnt++; if (out_data !== 16'h0001) $display("FAIL reset_data: got %h expected 0001", out_data); else pass_cnt++;
    reset = 1'b0;
    tick();
    total_cnt++; if (out_valid !== 1'b0 || out_data !== 16'h0001) $display("FAIL reset_idle: got valid %b data %h expected 0/0001", out_valid, out_data); else pass_cnt++;
  endtask

  task automatic test_free_run;
    logic [15:0] tbl [0:12];
    logic [15:0] m;
    tbl = '{16'h0001, 16'hB400, 16'h5A00, 16'h2D00, 16'h1680, 16'h0B40, 16'h05A0,
            16'h02D0, 16'h0168, 16'h00B4, 16'h005A, 16'h002D, 16'hB416};
    out_ready = 1'b1;
    do_load(16'h0001, 16'd0);
    m = 16'h0001;
    for (int i = 0; i < 256; i++) begin
      if (i < 13) begin
        total_cnt++; if (out_data !== tbl[i]) $display("FAIL free_table[%0d]: got %h expected %h", i, out_data, tbl[i]); else pass_cnt++;
      end
      total_cnt++; if (out_valid !== 1'b1 || done !== 1'b0 || out_data !== m) $display("FAIL free_run[%0d]: got v%b d%b %h expected v1 d0 %h", i, out_valid, done, out_data, m); else pass_cnt++;
      m = ref16(m);
      tick();
    end
    halt = 1'b1;
    tick();
    halt = 1'b0;
    total_cnt++; if (out_valid !== 1'b0 || busy !== 1'b0) $display("FAIL halt_idle: got valid %b busy %b expected 0/0", out_valid, busy); else pass_cnt++;
  endtask

  task automatic test_backpressure;
    out_ready = 1'b1;
    do_load(16'h0001, 16'd0);
    tick();
    tick();
    total_cnt++; if (out_data !== 16'h5A00) $display("FAIL bp_pre: got %h expected 5A00", out_data); else pass_cnt++;
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      total_cnt++; if (out_valid !== 1'b1 || out_data !== 16'h5A00) $display("FAIL bp_hold[%0d]: got v%b %h expected v1 5A00", i, out_valid, out_data); else pass_cnt++;
    end
    out_ready = 1'b1;
    tick();
    total_cnt++; if (out_data !== 16'h2D00) $display("FAIL bp_release: got %h expected 2D00", out_data); else pass_cnt++;
    halt = 1'b1;
    tick();
    halt = 1'b0;
  endtask

  task automatic test_finite_burst;
    bit          rdy_pat [0:3];
    logic [15:0] acc [$];
    logic [15:0] m;
    int          rem, done_seen;
    bit          exp_done;
    rdy_pat = '{1'b1, 1'b0, 1'b1, 1'b1};
    out_ready = 1'b0;
    do_load(16'h0001, 16'd3);
    m = 16'h0001; rem = 3; done_seen = 0;
    for (int c = 0; c < 7; c++) begin
      out_ready = (c < 4) ? rdy_pat[c] : 1'b1;
      exp_done = 1'b0;
      if (out_valid && out_ready) begin
        acc.push_back(out_data);
        m = ref16(m);
        rem--;
        exp_done = (rem == 0);
      end
      tick();
      if (done) done_seen++;
      total_cnt++; if (done !== exp_done) $display("FAIL burst_done[%0d]: got %b expected %b", c, done, exp_done); else pass_cnt++;
      total_cnt++; if (busy !== (rem != 0)) $display("FAIL burst_busy[%0d]: got %b expected %b", c, busy, rem != 0); else pass_cnt++;
    end
    total_cnt++; if (acc.size() != 3 || done_seen != 1) $display("FAIL burst_count: got %0d words %0d dones expected 3/1", acc.size(), done_seen); else pass_cnt++;
    if (acc.size() == 3) begin
      total_cnt++; if (acc[0] !== 16'h0001 || acc[1] !== 16'hB400 || acc[2] !== 16'h5A00)
        $display("FAIL burst_words: got %h %h %h expected 0001 B400 5A00", acc[0], acc[1], acc[2]); else pass_cnt++;
    end
  endtask

  task automatic test_zero_reload;
    int dones;
    out_ready = 1'b0;
    do_load(16'h0000, 16'd2);
    total_cnt++; if (out_valid !== 1'b1 || out_data !== 16'h0001) $display("FAIL zero_seed: got v%b %h expected v1 0001", out_valid, out_data); else pass_cnt++;
    out_ready = 1'b1;
    tick();
    // one word left: a reload with a same-cycle handshake must win and suppress done
    load = 1'b1; seed = 16'hACE1; len = 16'd3;
    tick();
    load = 1'b0;
    total_cnt++; if (out_data !== 16'hACE1 || done !== 1'b0 || busy !== 1'b1) $display("FAIL reload: got %h done %b busy %b expected ACE1 0 1", out_data, done, busy); else pass_cnt++;
    dones = 0;
    repeat (4) begin
      tick();
      if (done) dones++;
    end
    total_cnt++; if (dones != 1 || busy !== 1'b0) $display("FAIL reload_drain: got %0d dones busy %b expected 1/0", dones, busy); else pass_cnt++;
  endtask

  task automatic test_reset_midrun;
    out_ready = 1'b1;
    do_load(16'h1234, 16'd0);
    tick(); tick();
    reset = 1'b1; load = 1'b1; seed = 16'h5555;
    tick();
    reset = 1'b0; load = 1'b0;
    total_cnt++; if (out_valid !== 1'b0 || busy !== 1'b0 || out_data !== 16'h0001) $display("FAIL reset_midrun: got v%b b%b %h expected 0 0 0001", out_valid, busy, out_data); else pass_cnt++;
  endtask

  task automatic test_random;
    logic [15:0] cur, s, l;
    int          rem;
    bit          run, exp_done, ld, hl, rd;
    reset = 1'b1; tick(); reset = 1'b0;
    cur = 16'h0001; rem = 0; run = 1'b0;
    for (int c = 0; c < 1500; c++) begin
      ld = ($urandom_range(0, 19) == 0) || (!run && $urandom_range(0, 3) == 0);
      s  = ($urandom_range(0, 7) == 0) ? 16'h0000 : 16'($urandom);
      l  = 16'($urandom_range(0, 6));
      hl = ($urandom_range(0, 39) == 0);
      rd = ($urandom_range(0, 2) != 0);
      load = ld; seed = s; len = l; halt = hl; out_ready = rd;
      exp_done = 1'b0;
      if (ld) begin
        run = 1'b1; cur = (s == 16'h0000) ? 16'h0001 : s; rem = int'(l);
      end else if (run) begin
        if (rd) begin
          cur = ref16(cur);
          if (rem > 0) begin
            rem--;
            if (rem == 0) begin run = 1'b0; exp_done = 1'b1; end
          end
        end
        if (hl) run = 1'b0;
      end
      tick();
      total_cnt++; if (out_valid !== run || busy !== run || done !== exp_done || out_data !== cur)
        $display("FAIL random[%0d]: got v%b b%b d%b %h expected v%b b%b d%b %h", c, out_valid, busy, done, out_data, run, run, exp_done, cur); else pass_cnt++;
    end
    load = 1'b0; halt = 1'b0;
  endtask

  task automatic test_period;
    bit         seen [0:15];
    logic [3:0] m;
    bit         exp_wrap;
    for (int i = 0; i < 16; i++) seen[i] = 1'b0;
    load4 = 1'b1; seed4 = 4'h1;
    tick();
    load4 = 1'b0;
    m = 4'h1;
    seen[1] = 1'b1;
    for (int k = 1; k <= 30; k++) begin
      m = ref4(m);
      tick();
      exp_wrap = PC_EN && (k == 15 || k == 30);
      total_cnt++; if (wrap4 !== exp_wrap || out_data4 !== m) $display("FAIL period[%0d]: got wrap %b %h expected wrap %b %h", k, wrap4, out_data4, exp_wrap, m); else pass_cnt++;
      if (k < 15) begin
        total_cnt++; if (out_data4 === 4'h0 || seen[out_data4]) $display("FAIL period_distinct[%0d]: got %h repeated or zero expected new non-zero", k, out_data4); else pass_cnt++;
        seen[out_data4] = 1'b1;
      end
    end
`ifdef LFSR_PERIOD_CHECK_EN
    total_cnt++; if (u4.period_q !== 5'd30) $display("FAIL period_count: got %0d expected 30", u4.period_q); else pass_cnt++;
`endif
  endtask

  initial begin
    reset = 1'b1; load = 1'b0; halt = 1'b0; out_ready = 1'b0;
    seed = 16'h0; len = 16'h0; load4 = 1'b0; seed4 = 4'h0;
    test_reset();
    test_free_run();
    test_backpressure();
    test_finite_burst();
    test_zero_reload();
    test_reset_midrun();
    test_random();
    test_period();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got no completion expected finish within 2 ms");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/lfsr_prng.md
Name: lfsr_prng

Overview:
- Parametrised Galois LFSR pseudo-random word generator with a valid/ready output stream, seed loading and burst-length control.
- Successor to the fixed 16-bit seeded LFSR: generalised width and tap mask, backpressure-safe output, finite bursts, lock-up protection.
- Feeds test-pattern and stimulus generators in the digit-recognition datapath.
- Output sequence is bit-exact against the Matlab golden model for the same WIDTH, TAPS and seed.

Parameters:
- WIDTH, 16: LFSR and output word width. Legal range 3..32.
- TAPS, 16'hB400: Galois feedback mask, WIDTH bits wide. The default is x^16+x^14+x^13+x^11+1, which is maximal length (period 65535).
- DEFAULT_SEED, 1: substituted whenever an all-zero seed is loaded. Must be non-zero.
- LEN_W, 16: width of the burst-length input and counter.

Ports:
- clk  in  1  single system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- load  in  1  one-cycle pulse: capture seed and len, then start generating.
- seed  in  WIDTH  seed value, sampled when load=1.
- len  in  LEN_W  number of words to emit; 0 means free-running. Sampled when load=1.
- halt  in  1  level input; when 1, the block returns to S_IDLE after the current handshake.
- out_valid  out  1  out_data is valid.
- out_ready  in  1  downstream accepts out_data.
- out_data  out  WIDTH  current LFSR state.
- busy  out  1  high in S_RUN.
- done  out  1  one-cycle pulse when the last word of a finite burst is accepted.
- wrap  out  1  period-check pulse (optional feature); tied to 0 when the feature is compiled out.

Behaviour:
- Reset values:
  - state S_IDLE; lfsr = DEFAULT_SEED; cnt = 0
  - out_valid = 0, busy = 0, done = 0, wrap = 0
  - out_data = DEFAULT_SEED
- States:
  - S_IDLE
    - load -> S_RUN; lfsr <= (seed == 0) ? DEFAULT_SEED : seed; cnt <= len.
  - S_RUN
    - out_valid = 1; out_data = lfsr (registered, so no combinational path from out_ready to out_data).
    - Handshake (out_valid & out_ready): lfsr <= step(lfsr). If len was non-zero, cnt <= cnt - 1.
    - Accepting a word with cnt == 1 -> S_IDLE and done = 1 for the next cycle.
    - halt = 1 on any cycle -> S_IDLE at the next edge. The pending word is dropped unless it handshakes that same cycle, in which case it counts as accepted.
  - Latency: load at edge N gives out_valid = 1 with out_data = loaded seed after edge N+1.
- Step function (Galois): nxt = (lfsr >> 1) ^ (lfsr[0] ? TAPS : 0).
- Backpressure: while out_valid & !out_ready, out_data holds stable and the LFSR does not advance.
- load while in S_RUN: reseeds and reloads cnt at the next edge; the old word is discarded and done is not pulsed. load takes priority over halt and over a same-cycle handshake.
- reset while in S_RUN: immediate return to reset values at the next edge; reset has priority over everything.
- Counter is LEN_W wide. Free-running mode (len = 0) never decrements cnt and never asserts done.
- The all-zero state cannot be reached: zero seeds are replaced and the tap mask is non-zero.

Optional Feature:
- Macro: LFSR_PERIOD_CHECK_EN.
- Defined:
  - A start register captures the effective seed at load.
  - wrap pulses for one cycle when a handshake advances lfsr back to the start value.
  - A WIDTH+1-bit period counter counts handshakes since load. It is readable only in simulation, via a hierarchical reference.
- Undefined: no start register and no counter; wrap is driven to constant 0.

Decomposition:
- lfsr_pkg holds:
  - the state enum (S_IDLE, S_RUN)
  - default tap constants: TAPS_16 = 16'hB400, TAPS_4 = 4'hC, TAPS_8 = 8'hB8, TAPS_32 = 32'h80200003
- Sub-module lfsr_step: purely combinational next-state function, parametrised by WIDTH and TAPS, shared with future multi-step variants.

Test Plan:
- Reset:
  - Stimulus: hold reset for 3 cycles, then release.
  - Required: out_valid = 0, busy = 0, done = 0, out_data = 0x0001.
- Free-running with seed 1:
  - Stimulus: load seed = 16'h0001, len = 0, out_ready = 1.
  - Required: out_data sequence 0001, B400, 5A00, 2D00, 1680, 0B40, 05A0, 02D0, 0168, 00B4, 005A, 002D, B416.
  - Required: first 256 words match the Matlab results file.
- Backpressure:
  - Stimulus: out_ready = 0 for 5 cycles while out_data = 5A00.
  - Required: out_data stays 5A00; on release the next word is 2D00 with no skip or duplicate.
- Finite burst:
  - Stimulus: load seed = 1, len = 3, out_ready toggling 1,0,1,1.
  - Required: exactly three words 0001, B400, 5A00 accepted.
  - Required: done pulses once on the cycle after the third acceptance; busy falls at the same time.
- Zero seed and reload:
  - Stimulus: load seed = 0.
  - Required: first word = 0001.
  - Stimulus: mid-burst, load seed = 16'hACE1.
  - Required: next valid word = ACE1 and no done pulse.
- Period check (LFSR_PERIOD_CHECK_EN defined):
  - Configuration: WIDTH = 4, TAPS = 4'hC, seed = 1, out_ready = 1.
  - Required: wrap pulses after exactly 15 handshakes and again after 30.
  - Required: the 15 distinct values include no 0.
